// File: rtl/video_pkg.sv
// video_pkg: shared widths and unpack phase encoding for the RGB video path
package video_pkg;
  localparam int PIXEL_W = 24;
  localparam int AXIS_W = 32;
  typedef enum logic [1:0] {P0, P1, P2, EXTRA} phase_t;
  function automatic phase_t next_phase(input phase_t p);
    return p == P0 ? P1 : p == P1 ? P2 : p == P2 ? EXTRA : P0;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with flush, level output and push-while-full when popping
module sync_fifo #(
  parameter int W = 24,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wptr, rptr;
  logic do_push, do_pop;
  assign level = wptr - rptr;
  assign empty = wptr == rptr;
  assign full = level == (AW+1)'(DEPTH);
  assign do_pop = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);
  assign dout = mem[rptr[AW-1:0]];
  // pointers carry an extra MSB so full and empty are distinguishable
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
    end
  end
  // storage array, no reset needed since pointers gate visibility
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/axis_rgb_unpacker.sv
// axis_rgb_unpacker: unpacks a 32-bit little-endian RGB byte stream into 24-bit pixels for a video driver
module axis_rgb_unpacker
  import video_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter logic [PIXEL_W-1:0] UNDERFLOW_COLOR = 24'h000000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [AXIS_W-1:0]             s_axis_tdata,
  input  logic                          s_axis_tvalid,
  input  logic                          s_axis_tlast,
  output logic                          s_axis_tready,
  input  logic                          flush,
  input  logic                          data_req,
  output logic [PIXEL_W-1:0]            pixel_data,
  output logic                          underflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  phase_t state;
  logic [23:0] held;
  logic [PIXEL_W-1:0] push_pix, fifo_dout;
  logic fifo_full, fifo_empty, accept, extra_push, pop_ok, cut;
  assign s_axis_tready = !rst && !flush && state != EXTRA && !fifo_full;
  assign accept = s_axis_tvalid && s_axis_tready;
  assign pop_ok = data_req && !flush && !fifo_empty;
  assign extra_push = !rst && !flush && state == EXTRA && (!fifo_full || pop_ok);
  assign cut = s_axis_tlast && state != P2;
  // pixel assembled from the current word and the bytes held from earlier words
  always_comb begin
    push_pix = state == P0 ? s_axis_tdata[23:0] :
               state == P1 ? {s_axis_tdata[15:0], held[7:0]} :
               state == P2 ? {s_axis_tdata[7:0], held[15:0]} : held;
  end
  sync_fifo #(.W(PIXEL_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (accept || extra_push),
    .din   (push_pix),
    .pop   (data_req),
    .dout  (fifo_dout),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );
  // phase FSM: tlast drops residue except after P2, whose leftover pixel still drains through EXTRA
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state <= P0;
      held <= '0;
    end else if (accept) begin
      state <= cut ? P0 : next_phase(state);
      held <= cut ? 24'h0 :
              state == P0 ? {16'h0, s_axis_tdata[31:24]} :
              state == P1 ? {8'h0, s_axis_tdata[31:16]} : s_axis_tdata[31:8];
    end else if (extra_push) begin
      state <= P0;
      held <= '0;
    end
  end
  // one-cycle pixel delivery; empty requests outside a flush mark sticky underflow
  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_data <= '0;
      underflow <= 1'b0;
    end else if (data_req) begin
      pixel_data <= pop_ok ? fifo_dout : UNDERFLOW_COLOR;
      underflow <= underflow || (!flush && fifo_empty);
    end
  end
endmodule

// File: tb/tb_axis_rgb_unpacker.sv
// tb_axis_rgb_unpacker: randomized and directed scoreboard bench against a byte-stream reference model
module tb_axis_rgb_unpacker;
  localparam int D = 16;
  localparam logic [23:0] UC = 24'hFF00FF;
  logic clk = 0, rst = 1;
  logic [31:0] s_axis_tdata = 0;
  logic s_axis_tvalid = 0, s_axis_tlast = 0, flush = 0, data_req = 0;
  logic s_axis_tready, underflow;
  logic [23:0] pixel_data;
  logic [4:0] fifo_level;
  int total = 0, bad = 0;

  axis_rgb_unpacker #(.FIFO_DEPTH(D), .UNDERFLOW_COLOR(UC)) dut (
    .clk(clk), .rst(rst), .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready), .flush(flush),
    .data_req(data_req), .pixel_data(pixel_data), .underflow(underflow), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, a, e, $time);
    end
  endtask

  // reference model: bytes of the current line, pixels stored, one pixel waiting for space
  logic [7:0] lb [$];
  logic [23:0] fq [$];
  logic [23:0] exp_q [$];
  logic [23:0] got [$];
  bit pend = 0, uf = 0, req_flag = 0;
  logic [23:0] pend_pix = 0, last_exp = 0;

  always @(posedge clk) begin
    bit t_exp, popped;
    t_exp = !rst && !flush && !pend && fq.size() < D;
    chk("tready", s_axis_tready, t_exp);
    req_flag = 0;
    if (rst) begin
      fq.delete(); lb.delete(); exp_q.delete();
      pend = 0; uf = 0; last_exp = 0;
    end else if (flush) begin
      if (data_req) begin exp_q.push_back(UC); req_flag = 1; end
      fq.delete(); lb.delete(); pend = 0;
    end else begin
      popped = data_req && fq.size() > 0;
      if (data_req) begin
        req_flag = 1;
        if (popped) exp_q.push_back(fq.pop_front());
        else begin exp_q.push_back(UC); uf = 1; end
      end
      if (pend && fq.size() < D) begin fq.push_back(pend_pix); pend = 0; end
      if (t_exp && s_axis_tvalid) begin
        for (int i = 0; i < 4; i++) lb.push_back(s_axis_tdata[8*i +: 8]);
        fq.push_back({lb[2], lb[1], lb[0]});
        repeat (3) void'(lb.pop_front());
        if (lb.size() >= 3) begin
          pend = 1;
          pend_pix = {lb[2], lb[1], lb[0]};
          repeat (3) void'(lb.pop_front());
        end
        if (s_axis_tlast) lb.delete();
      end
    end
  end

  // monitor: compares registered outputs just after each edge
  always @(posedge clk) begin
    #1;
    if (req_flag) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL pixel_noexp got=%h", pixel_data);
      end else begin
        last_exp = exp_q.pop_front();
        chk("pixel", pixel_data, last_exp);
        got.push_back(pixel_data);
      end
    end else chk("pixel_hold", pixel_data, last_exp);
    chk("level", fifo_level, fq.size());
    chk("underflow", underflow, uf);
  end

  task automatic step(input bit v, input logic [31:0] d, input bit l, input bit r, input bit f);
    @(negedge clk);
    s_axis_tvalid = v; s_axis_tdata = d; s_axis_tlast = l; data_req = r; flush = f;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0);
  endtask

  task automatic send(input logic [31:0] d, input bit l);
    int n = 0;
    step(1, d, l, 0, 0); #1;
    while (!s_axis_tready && n < 200) begin step(1, d, l, 0, 0); #1; n++; end
    if (n >= 200) begin total++; bad++; $display("FAIL send_timeout word=%h", d); end
  endtask

  task automatic chk_got(input string nm, input int i, input logic [23:0] e);
    if (i >= got.size()) begin total++; bad++; $display("FAIL %s missing exp=%h", nm, e); end
    else chk(nm, got[i], e);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 0;
    idle(2);
    // packing across a three-word group
    got.delete();
    send(32'h44332211, 0); send(32'h88776655, 0); send(32'hCCBBAA99, 0);
    idle(2);
    repeat (4) step(0, 0, 0, 1, 0);
    idle(2);
    chk_got("pack0", 0, 24'h332211); chk_got("pack1", 1, 24'h665544);
    chk_got("pack2", 2, 24'h998877); chk_got("pack3", 3, 24'hCCBBAA);
    // tlast in P0 drops the leftover byte
    got.delete();
    send(32'h44332211, 1); send(32'h88776655, 0);
    idle(1);
    repeat (2) step(0, 0, 0, 1, 0);
    idle(2);
    chk_got("tlast0", 0, 24'h332211); chk_got("tlast1", 1, 24'h776655);
    step(0, 0, 0, 0, 1);
    idle(1);
    // fill to full, stall a word, then drain everything
    for (int i = 0; i < 12; i++) send({4{8'(i + 1)}}, 0);
    idle(2); #1;
    chk("full_level", fifo_level, 16);
    chk("full_tready", s_axis_tready, 0);
    step(0, 0, 0, 1, 0);
    idle(1); #1;
    chk("tready_back", s_axis_tready, 1);
    repeat (2) step(0, 0, 0, 0, 0);
    repeat (15) step(0, 0, 0, 1, 0);
    idle(2);
    // flush at level 5 while in P1
    for (int i = 0; i < 4; i++) send(32'hA0A1A2A3 + i, 0);
    idle(2); #1;
    chk("pre_flush_level", fifo_level, 5);
    step(0, 0, 0, 0, 1);
    idle(1); #1;
    chk("post_flush_level", fifo_level, 0);
    got.delete();
    send(32'h44332211, 0);
    idle(1);
    step(0, 0, 0, 1, 0);
    idle(2);
    chk_got("after_flush", 0, 24'h332211);
    step(0, 0, 0, 0, 1);
    idle(1);
    // reset while in EXTRA with a word presented
    send(32'h0B0A0908, 0); send(32'h0F0E0D0C, 0); send(32'h13121110, 0);
    step(1, 32'h57565554, 0, 0, 0);
    rst = 1;
    @(negedge clk); @(negedge clk);
    rst = 0; #1;
    chk("rst_pixel", pixel_data, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_underflow", underflow, 0);
    chk("rst_tready", s_axis_tready, 1);
    got.delete();
    idle(2);
    step(0, 0, 0, 1, 0);
    idle(2);
    chk_got("rst_reaccept", 0, 24'h565554);
    step(0, 0, 0, 0, 1);
    idle(1);
    // underflow is sticky
    step(0, 0, 0, 1, 0);
    idle(1); #1;
    chk("uf_pixel", pixel_data, UC);
    chk("uf_flag", underflow, 1);
    idle(100); #1;
    chk("uf_sticky", underflow, 1);
    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      step($urandom % 4 != 0, $urandom, $urandom % 8 == 0, $urandom % 3 == 0, $urandom % 64 == 0);
      rst = ($urandom % 300 == 0);
    end
    rst = 0;
    idle(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
